// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus levels shared by the I2C master/slave blocks
package i2c_pkg;
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR     = 4'd1;
    localparam logic [3:0] S_ACK_A    = 4'd2;
    localparam logic [3:0] S_PTR      = 4'd3;
    localparam logic [3:0] S_ACK_P    = 4'd4;
    localparam logic [3:0] S_WR       = 4'd5;
    localparam logic [3:0] S_ACK_W    = 4'd6;
    localparam logic [3:0] S_RD_FETCH = 4'd7;
    localparam logic [3:0] S_RD       = 4'd8;
    localparam logic [3:0] S_RD_ACK   = 4'd9;
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-FF synchroniser, FILT-deep glitch filter and edge pulses for one bus line
module i2c_line_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(FILT + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    // filtered line follows the synchronised input only after FILT consecutive differing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b11;
            cnt  <= '0;
            line <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], line_i};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == line)
                cnt <= '0;
            else if (cnt == CW'(FILT - 1)) begin
                cnt  <= '0;
                line <= sync[1];
                rise <= sync[1];
                fall <= !sync[1];
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: I2C slave mapping pointer-addressed burst reads/writes onto a synchronous register file
module i2c_slave_regif
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR   = 7'h00,
    parameter int         MEM_AW = 5,
    parameter int         FILT   = 3,
    parameter bit         WRAP   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    output logic              scl_o,
    output logic              scl_t,
    input  logic              sda_i,
    output logic              sda_o,
    output logic              sda_t,
    input  logic [7:0]        data_in,
    output logic              RE,
    output logic              WE,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        data_out,
    output logic              busy
);
    logic              scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
    logic [3:0]        state, bit_cnt;
    logic [6:0]        shreg;
    logic [7:0]        tx, nxt;
    logic              rw, start, stop;
    logic [MEM_AW-1:0] ptr_inc;

    assign scl_o   = 1'b0;
    assign scl_t   = 1'b1;
    assign sda_o   = 1'b0;
    assign start   = sda_fall && scl;
    assign stop    = sda_rise && scl;
    assign nxt     = {shreg, sda};
    assign ptr_inc = (!WRAP && &mem_addr) ? mem_addr : mem_addr + 1'b1;

    i2c_line_filter #(.FILT(FILT)) u_scl (
        .clk(clk), .rst(rst), .line_i(scl_i), .line(scl), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_line_filter #(.FILT(FILT)) u_sda (
        .clk(clk), .rst(rst), .line_i(sda_i), .line(sda), .rise(sda_rise), .fall(sda_fall)
    );

    // bus protocol FSM; START/STOP override bit handling, ACK phases use sda_t to tell first from second scl_fall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            bit_cnt  <= 4'd0;
            shreg    <= 7'd0;
            tx       <= 8'd0;
            rw       <= 1'b0;
            sda_t    <= 1'b1;
            RE       <= 1'b0;
            WE       <= 1'b0;
            mem_addr <= '0;
            data_out <= 8'd0;
            busy     <= 1'b0;
        end else begin
            WE <= 1'b0;
            RE <= 1'b0;
            if (start) begin
                sda_t   <= 1'b1;
                bit_cnt <= 4'd0;
                state   <= S_ADDR;
            end else if (stop) begin
                sda_t <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
            end else begin
                case (state)
                    S_ADDR: if (scl_rise) begin
                        shreg   <= nxt[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            rw      <= nxt[0];
                            busy    <= nxt[7:1] == ADDR;
                            state   <= (nxt[7:1] == ADDR) ? S_ACK_A : S_IDLE;
                        end
                    end
                    // a read fetches during the ACK clock so bit 7 is ready at the fall ending it
                    S_ACK_A: if (scl_fall) begin
                        if (rw) begin
                            sda_t <= ACK;
                            RE    <= 1'b1;
                            state <= S_RD_FETCH;
                        end else if (sda_t)
                            sda_t <= ACK;
                        else begin
                            sda_t <= 1'b1;
                            state <= S_PTR;
                        end
                    end
                    S_PTR: if (scl_rise) begin
                        shreg   <= nxt[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt  <= 4'd0;
                            mem_addr <= nxt[MEM_AW-1:0];
                            state    <= S_ACK_P;
                        end
                    end
                    S_ACK_P: if (scl_fall) begin
                        sda_t <= sda_t ? ACK : 1'b1;
                        state <= sda_t ? S_ACK_P : S_WR;
                    end
                    S_WR: if (scl_rise) begin
                        shreg   <= nxt[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt  <= 4'd0;
                            data_out <= nxt;
                            WE       <= 1'b1;
                            state    <= S_ACK_W;
                        end
                    end
                    S_ACK_W: if (scl_fall) begin
                        sda_t    <= sda_t ? ACK : 1'b1;
                        mem_addr <= sda_t ? mem_addr : ptr_inc;
                        state    <= sda_t ? S_ACK_W : S_WR;
                    end
                    // RE is high in the first cycle here; data_in is valid the cycle after
                    S_RD_FETCH: if (!RE) begin
                        tx    <= data_in;
                        state <= S_RD;
                    end
                    S_RD: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_t   <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= S_RD_ACK;
                        end else begin
                            sda_t   <= tx[7];
                            tx      <= {tx[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    S_RD_ACK: if (scl_rise) begin
                        if (sda == NACK) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            mem_addr <= ptr_inc;
                            RE       <= 1'b1;
                            state    <= S_RD_FETCH;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_regif.sv
// tb_i2c_slave_regif: bit-banged I2C master against two slaves (wrapping and saturating) with a register-file model
module tb_i2c_slave_regif;
    localparam int Q = 100;

    logic clk = 1'b0, rst = 1'b0, m_scl = 1'b1, m_sda = 1'b1, glitch = 1'b0;
    logic scl_o0, scl_t0, sda_o0, sda_t0, re0, we0, busy0;
    logic scl_o1, scl_t1, sda_o1, sda_t1, re1, we1, busy1;
    logic [4:0] addr0, addr1;
    logic [7:0] din0, din1, dout0, dout1;
    logic [7:0] mem0 [32], mem1 [32], ref0 [32], ref1 [32];
    logic [7:0] wbuf [8], rbuf [8];
    logic [12:0] we_q0 [$], we_q1 [$];
    logic [4:0]  re_q0 [$], re_q1 [$];
    logic busy_seen0;
    int n_tests = 0, n_fail = 0, overlap = 0;

    wire scl_bus = m_scl & (scl_t0 | scl_o0) & (scl_t1 | scl_o1);
    wire sda_bus = m_sda & (sda_t0 | sda_o0) & (sda_t1 | sda_o1);

    always #5 clk = ~clk;

    i2c_slave_regif #(.ADDR(7'h2A), .MEM_AW(5), .FILT(3), .WRAP(1'b1)) dut0 (
        .clk(clk), .rst(rst), .scl_i(scl_bus), .scl_o(scl_o0), .scl_t(scl_t0),
        .sda_i(sda_bus), .sda_o(sda_o0), .sda_t(sda_t0), .data_in(din0), .RE(re0), .WE(we0),
        .mem_addr(addr0), .data_out(dout0), .busy(busy0)
    );
    i2c_slave_regif #(.ADDR(7'h35), .MEM_AW(5), .FILT(3), .WRAP(1'b0)) dut1 (
        .clk(clk), .rst(rst), .scl_i(scl_bus), .scl_o(scl_o1), .scl_t(scl_t1),
        .sda_i(sda_bus), .sda_o(sda_o1), .sda_t(sda_t1), .data_in(din1), .RE(re1), .WE(we1),
        .mem_addr(addr1), .data_out(dout1), .busy(busy1)
    );

    // register-file stubs: read data one cycle after RE, writes on WE
    always @(posedge clk) begin
        if (re0) din0 <= mem0[addr0];
        if (re1) din1 <= mem1[addr1];
        if (we0) mem0[addr0] = dout0;
        if (we1) mem1[addr1] = dout1;
    end

    // strobe monitors sampled away from the active edge
    always @(negedge clk) begin
        if (we0) we_q0.push_back({addr0, dout0});
        if (we1) we_q1.push_back({addr1, dout1});
        if (re0) re_q0.push_back(addr0);
        if (re1) re_q1.push_back(addr1);
        if ((we0 && re0) || (we1 && re1)) overlap++;
        if (busy0) busy_seen0 = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        we_q0.delete(); we_q1.delete(); re_q0.delete(); re_q1.delete();
        busy_seen0 = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic clk_bit(input logic b, output logic r);
        m_sda = b; #Q; m_scl = 1'b1;
        if (glitch) begin
            #30; m_scl = 1'b0; #20; m_scl = 1'b1; #(Q - 50);
        end else #Q;
        r = sda_bus; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic wr_byte(input logic [7:0] b, input int gbit, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            glitch = (i == gbit);
            clk_bit(b[i], r);
        end
        glitch = 1'b0;
        clk_bit(1'b1, ack);
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic mack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            d[i] = r;
        end
        clk_bit(mack, r);
    endtask

    // address + pointer + n data bytes, left open (no STOP)
    task automatic write_burst(input logic [6:0] a, input logic [7:0] p, input int n, input int gbit);
        logic ack;
        i2c_start();
        wr_byte({a, 1'b0}, gbit, ack); check("ack_waddr", ack, 1'b0);
        wr_byte(p, -1, ack);           check("ack_ptr", ack, 1'b0);
        for (int i = 0; i < n; i++) begin
            wr_byte(wbuf[i], -1, ack); check("ack_data", ack, 1'b0);
        end
    endtask

    // pointer write, repeated START, n reads with NACK on the last, left open (no STOP)
    task automatic read_burst(input logic [6:0] a, input logic [7:0] p, input int n);
        logic ack;
        write_burst(a, p, 0, -1);
        i2c_start();
        wr_byte({a, 1'b1}, -1, ack); check("ack_raddr", ack, 1'b0);
        for (int i = 0; i < n; i++) rd_byte(rbuf[i], i == n - 1);
    endtask

    // model: burst of n writes from pointer p, modulo-32 pointer
    task automatic expect_we0(input int p, input int n);
        int q = p;
        check("we0_count", we_q0.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < we_q0.size()) check("we0_evt", we_q0[i], {q[4:0], wbuf[i]});
            ref0[q] = wbuf[i];
            q = (q + 1) % 32;
        end
        check("we0_ptr_end", addr0, q);
        check("re0_none", re_q0.size(), 0);
    endtask

    task automatic expect_rd0(input int p, input int n);
        int q = p;
        check("re0_count", re_q0.size(), n);
        for (int i = 0; i < n; i++) begin
            check("rd0_data", rbuf[i], ref0[q]);
            if (i < re_q0.size()) check("re0_addr", re_q0[i], q);
            if (i < n - 1) q = (q + 1) % 32;
        end
        check("rd0_ptr_end", addr0, q);
        check("we0_none_rd", we_q0.size(), 0);
    endtask

    initial begin
        logic r;
        int p, n;
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 8'($urandom); ref0[i] = mem0[i];
            mem1[i] = 8'($urandom); ref1[i] = mem1[i];
        end
        #42;
        check("rst_sda_t", sda_t0, 1'b1);
        check("rst_re", re0, 1'b0);
        check("rst_we", we0, 1'b0);
        check("rst_addr", addr0, 5'd0);
        check("rst_dout", dout0, 8'd0);
        check("rst_busy", busy0, 1'b0);
        check("rst_sda_t1", sda_t1, 1'b1);
        #10 rst = 1'b1;
        #200;

        clear_mon();
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        write_burst(7'h2A, 8'h03, 2, -1);
        check("wr_busy_open", busy0, 1'b1);
        i2c_stop(); #Q;
        check("wr_busy_stop", busy0, 1'b0);
        expect_we0(3, 2);

        mem0[31] = 8'h11; ref0[31] = 8'h11; mem0[0] = 8'h22; ref0[0] = 8'h22;
        clear_mon();
        read_burst(7'h2A, 8'h1F, 2);
        check("rd_nack_idle", busy0, 1'b0);
        i2c_stop(); #Q;
        expect_rd0(31, 2);

        clear_mon();
        i2c_start();
        wr_byte(8'h56, -1, r); check("wrong_addr_nack", r, 1'b1);
        wr_byte(8'h10, -1, r);
        i2c_stop(); #Q;
        check("wrong_busy", busy_seen0, 1'b0);
        check("wrong_we", we_q0.size() + we_q1.size(), 0);
        check("wrong_re", re_q0.size() + re_q1.size(), 0);

        clear_mon();
        wbuf[0] = 8'($urandom);
        write_burst(7'h2A, 8'h08, 1, 3);
        i2c_stop(); #Q;
        expect_we0(8, 1);

        clear_mon();
        write_burst(7'h2A, 8'h0C, 0, -1);
        for (int i = 0; i < 4; i++) clk_bit(1'($urandom), r);
        i2c_stop(); #Q;
        check("part_we", we_q0.size(), 0);
        check("part_addr", addr0, 5'h0C);
        check("part_busy", busy0, 1'b0);

        clear_mon();
        for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
        write_burst(7'h35, 8'hFF, 3, -1);
        i2c_stop(); #Q;
        check("sat_count", we_q1.size(), 3);
        for (int i = 0; i < 3 && i < we_q1.size(); i++) check("sat_evt", we_q1[i], {5'h1F, wbuf[i]});
        check("sat_addr", addr1, 5'h1F);
        check("sat_dut0_quiet", we_q0.size(), 0);

        for (int k = 0; k < 6; k++) begin
            p = $urandom_range(0, 31);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            clear_mon();
            write_burst(7'h2A, {3'($urandom), 5'(p)}, n, -1);
            i2c_stop(); #Q;
            expect_we0(p, n);
            p = $urandom_range(0, 31);
            n = $urandom_range(1, 4);
            clear_mon();
            read_burst(7'h2A, {3'($urandom), 5'(p)}, n);
            i2c_stop(); #Q;
            expect_rd0(p, n);
        end

        mem0[5] = 8'h3C; ref0[5] = 8'h3C;
        write_burst(7'h2A, 8'h05, 0, -1);
        i2c_start();
        wr_byte(8'h55, -1, r); check("rr_ack", r, 1'b0);
        check("rr_drive_low", sda_t0, 1'b0);
        #4 rst = 1'b0;
        #1;
        check("arst_sda_t", sda_t0, 1'b1);
        check("arst_re", re0, 1'b0);
        check("arst_we", we0, 1'b0);
        check("arst_addr", addr0, 5'd0);
        check("arst_dout", dout0, 8'd0);
        check("arst_busy", busy0, 1'b0);
        m_sda = 1'b1; m_scl = 1'b1;
        #100 rst = 1'b1;
        #100;

        check("we_re_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
